// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with shared debounce and one-entry key buffer
//
// Drives one keypad column low at a time, samples the synchronized rows,
// debounces with a single shared counter and hands accepted key codes to
// the consumer through a single-entry valid/ready buffer.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row_n[3:0] keypad rows, active-low, asynchronous to clk
//   col_n[3:0] column drive, active-low, exactly one bit low
//   key_code   accepted key = {row[1:0], col[1:0]}
//   key_valid  key_code holds an unconsumed key
//   key_ready  consumer takes key_code when key_valid & key_ready
//   key_held   high while a debounced single key is held down
//   overrun    one-cycle pulse when an accepted key found the buffer full

module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 1200,
  parameter int DEB_CNT  = 240000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);
  localparam logic [19:0] DEB_LAST  = 20'(DEB_CNT - 1);

  logic [3:0]  rs_meta;
  logic [3:0]  rs;
  logic [1:0]  state, state_nx;
  logic [1:0]  col, col_nx;
  logic [19:0] cnt, cnt_nx;
  logic [3:0]  pat, pat_nx;
  logic        held_nx;
  logic        accept;
  logic [3:0]  pat_inv;
  logic        single_zero;
  logic [1:0]  row_idx;

  assign col_n = ~(4'b0001 << col);

  // Two-flop synchronizer; idle rows read as all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_meta <= 4'hF;
      rs      <= 4'hF;
    end else begin
      rs_meta <= row_n;
      rs      <= rs_meta;
    end
  end

  // A legal single press has exactly one row low in the latched pattern.
  assign pat_inv     = ~pat;
  assign single_zero = (pat_inv != 4'd0) && ((pat_inv & (pat_inv - 4'd1)) == 4'd0);

  always_comb begin
    row_idx = 2'd0;
    case (pat_inv)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Every counting path ends at its target with a transition that clears
  // cnt, so the counter can never run past its limit.
  always_comb begin
    state_nx = state;
    col_nx   = col;
    cnt_nx   = cnt;
    pat_nx   = pat;
    held_nx  = key_held;
    accept   = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nx = 20'd0;
          if (rs == 4'hF) begin
            col_nx = col + 2'd1;
          end else begin
            pat_nx   = rs;
            state_nx = DEBOUNCE;
          end
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      DEBOUNCE: begin
        if (rs != pat) begin
          pat_nx = rs;
          cnt_nx = 20'd0;
        end else if (cnt == DEB_LAST) begin
          cnt_nx = 20'd0;
          if (pat == 4'hF) begin
            // Settled back to idle: the press was noise, move on.
            state_nx = SCAN;
            col_nx   = col + 2'd1;
          end else begin
            // Multi-key patterns also park in PRESSED, but silently.
            state_nx = PRESSED;
            held_nx  = single_zero;
            accept   = single_zero;
          end
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      PRESSED: begin
        cnt_nx = 20'd0;
        if (rs == 4'hF) begin
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (rs != 4'hF) begin
          state_nx = PRESSED;
          cnt_nx   = 20'd0;
        end else if (cnt == DEB_LAST) begin
          state_nx = SCAN;
          cnt_nx   = 20'd0;
          col_nx   = col + 2'd1;
          held_nx  = 1'b0;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      default: begin
        state_nx = SCAN;
        cnt_nx   = 20'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SCAN;
      col      <= 2'd0;
      cnt      <= 20'd0;
      pat      <= 4'hF;
      key_held <= 1'b0;
    end else begin
      state    <= state_nx;
      col      <= col_nx;
      cnt      <= cnt_nx;
      pat      <= pat_nx;
      key_held <= held_nx;
    end
  end

  // Single-entry output buffer. A consume and a new accept in the same
  // cycle reload directly so key_valid never drops between the two keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (accept) begin
        if (!key_valid || key_ready) begin
          key_code  <= {row_idx, col};
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed self-checking bench for keypad_scan_ctrl

module tb_keypad_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overrun;

  // keys[r*4+c] = 1 means the key at row r, column c is pressed
  logic [15:0] keys;

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;
  int ov_cnt = 0;
  logic prev_valid = 1'b0;

  keypad_scan_ctrl #(.SCAN_DIV(8), .DEB_CNT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid && !prev_valid) rises++;
    prev_valid = key_valid;
    if (overrun) ov_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_valid", 32'(key_valid), 32'd1);
  endtask

  task automatic wait_held_low(input int budget);
    int n = 0;
    while (key_held !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_held_low", 32'(key_held), 32'd0);
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget);
    int n = 0;
    while (col_n !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_col", 32'(col_n), 32'(target));
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    int n;
    int r0;
    int o0;
    rst_n = 1'b0;
    keys = 16'h0;
    key_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_col_n", 32'(col_n), 32'hE);
    check_eq("rst_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_key_code", 32'(key_code), 32'd0);
    check_eq("rst_key_held", 32'(key_held), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    // Single press row2/col1 -> 9
    r0 = rises;
    keys[9] = 1'b1;
    wait_valid(300, n);
    check_eq("t1_code", 32'(key_code), 32'h9);
    check_eq("t1_held", 32'(key_held), 32'd1);
    pulse_ready();
    check_eq("t1_valid_drop", 32'(key_valid), 32'd0);
    keys = 16'h0;
    repeat (16) @(negedge clk);
    check_eq("t1_held_in_release", 32'(key_held), 32'd1);
    wait_held_low(40);
    check_eq("t1_next_col", 32'(col_n), 32'hB);
    check_eq("t1_one_code", 32'(rises - r0), 32'd1);

    // Bounce on row0/col3 -> 3, 2 sync + 16 + 1 cycles after last edge
    r0 = rises;
    wait_col(4'b0111, 100);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      keys[3] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    keys[3] = 1'b1;
    wait_valid(100, n);
    check_eq("t2_latency", 32'(n), 32'd19);
    check_eq("t2_code", 32'(key_code), 32'h3);
    check_eq("t2_one_code", 32'(rises - r0), 32'd1);
    pulse_ready();
    keys = 16'h0;
    wait_held_low(60);

    // Ghost: row1 and row3 at col0
    r0 = rises;
    keys[4] = 1'b1;
    keys[12] = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("t3_no_valid", 32'(key_valid), 32'd0);
    check_eq("t3_no_held", 32'(key_held), 32'd0);
    check_eq("t3_col_frozen", 32'(col_n), 32'hE);
    keys = 16'h0;
    repeat (10) @(negedge clk);
    check_eq("t3_col_in_release", 32'(col_n), 32'hE);
    wait_col(4'b1101, 40);
    check_eq("t3_no_code", 32'(rises - r0), 32'd0);

    // Backpressure: 5 then A with key_ready low
    r0 = rises;
    o0 = ov_cnt;
    keys[5] = 1'b1;
    wait_valid(200, n);
    check_eq("t4_code5", 32'(key_code), 32'h5);
    keys = 16'h0;
    wait_held_low(60);
    keys[10] = 1'b1;
    n = 0;
    while (ov_cnt == o0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_overrun", 32'(ov_cnt - o0), 32'd1);
    check_eq("t4_code_kept", 32'(key_code), 32'h5);
    check_eq("t4_valid_kept", 32'(key_valid), 32'd1);
    check_eq("t4_held_a", 32'(key_held), 32'd1);
    repeat (5) @(negedge clk);
    check_eq("t4_overrun_once", 32'(ov_cnt - o0), 32'd1);
    pulse_ready();
    check_eq("t4_consumed", 32'(key_valid), 32'd0);
    keys = 16'h0;
    wait_held_low(60);
    check_eq("t4_one_rise", 32'(rises - r0), 32'd1);

    // Reset mid-debounce on row0/col2 at cnt == 10
    wait_col(4'b1011, 100);
    r0 = rises;
    keys[2] = 1'b1;
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_col_n", 32'(col_n), 32'hE);
    check_eq("t5_rst_valid", 32'(key_valid), 32'd0);
    check_eq("t5_rst_code", 32'(key_code), 32'd0);
    check_eq("t5_rst_held", 32'(key_held), 32'd0);
    check_eq("t5_rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(200, n);
    check_eq("t5_code", 32'(key_code), 32'h2);
    check_eq("t5_held", 32'(key_held), 32'd1);
    keys = 16'h0;
    wait_held_low(60);
    check_eq("t5_one_code", 32'(rises - r0), 32'd1);

    // Simultaneous consume + accept of C while 2 is still buffered
    wait_col(4'b1110, 100);
    r0 = rises;
    o0 = ov_cnt;
    keys[12] = 1'b1;
    repeat (23) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check_eq("t6_code", 32'(key_code), 32'hC);
    check_eq("t6_valid", 32'(key_valid), 32'd1);
    check_eq("t6_no_overrun", 32'(ov_cnt - o0), 32'd0);
    check_eq("t6_no_gap", 32'(rises - r0), 32'd0);
    pulse_ready();
    check_eq("t6_consumed", 32'(key_valid), 32'd0);
    keys = 16'h0;
    wait_held_low(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
